// File: rtl/wbdualarb.sv
// wbdualarb: two-master / one-slave arbiter for a pipelined wishbone bus.
//
// Ownership is granted per bus cycle (cyc). A grant is never preempted:
// the non-owner waits until the owner drops cyc. Simultaneous requests
// from IDLE go to the master that did not own the bus last (round-robin).
// The arbiter counts outstanding requests so the owner can be stalled
// before the counter wraps. A watchdog aborts a cycle whose slave has
// stopped answering.
//
// Handshake: a request transfers on a clock edge where o_wb_stb is high
// and the owner's stall is low. The slave answers each request with
// exactly one i_wb_ack or aborts the cycle with i_wb_err. Responses go
// only to the current owner, and only while it still holds cyc.
//
// Ports
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_a_* / o_a_*          master A wishbone port (cyc, stb, we, addr,
//                          data, sel in; ack, stall, err, data out)
//   i_b_* / o_b_*          master B wishbone port, same set as A
//   o_wb_* / i_wb_*        shared slave wishbone port
//   o_dbg_state            current FSM state (IDLE=0, OWN_A=1, OWN_B=2,
//                          ABORT=3)
module wbdualarb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LGOUT   = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic            i_clk,
  input  logic            i_reset,
  // master A
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  // master B
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  // slave
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  // debug
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0]   WD_LAST  = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);
  localparam logic [LGOUT-1:0] NOUT_MAX = '1;

  // last_owner: 0 = A, 1 = B
  state_t           state, state_nxt;
  logic             last_owner, last_nxt;
  logic [LGOUT-1:0] nout, nout_nxt;
  logic [WDW-1:0]   wd, wd_nxt;

  logic             own_a, own_b, owned;
  logic             m_cyc, m_stb, m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  logic [DW/8-1:0]  m_sel;
  logic             m_stall, m_ack, m_err;
  logic             nout_full, wd_fire, accept;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);
  assign owned = own_a | own_b;

  // Owner's request signals; only meaningful while owned.
  assign m_cyc  = own_b ? i_b_cyc  : i_a_cyc;
  assign m_stb  = own_b ? i_b_stb  : i_a_stb;
  assign m_we   = own_b ? i_b_we   : i_a_we;
  assign m_addr = own_b ? i_b_addr : i_a_addr;
  assign m_data = own_b ? i_b_data : i_a_data;
  assign m_sel  = own_b ? i_b_sel  : i_a_sel;

  assign nout_full = (nout == NOUT_MAX);

  // The watchdog reaches TIMEOUT on this cycle: the counter already holds
  // TIMEOUT-1 and this cycle is another silent one.
  assign wd_fire = (TIMEOUT != 0) && owned && m_cyc && (nout != '0) &&
                   !i_wb_ack && !i_wb_err && (wd == WD_LAST);

  assign accept = o_wb_stb && !m_stall;

  assign o_dbg_state = state;

  // Bus outputs
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_a_stall = 1'b1;
    o_a_data  = '0;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_data  = '0;
    m_stall   = 1'b1;
    m_ack     = 1'b0;
    m_err     = 1'b0;

    if (owned) begin
      o_a_data = i_wb_data;
      o_b_data = i_wb_data;
      if (wd_fire) begin
        // Abort: report the error to the owner and release the slave.
        m_err = 1'b1;
      end else begin
        o_wb_cyc  = m_cyc;
        o_wb_stb  = m_cyc & m_stb;
        o_wb_we   = m_we;
        o_wb_addr = m_addr;
        o_wb_data = m_data;
        o_wb_sel  = m_sel;
        m_stall   = i_wb_stall | nout_full;
        m_ack     = i_wb_ack & m_cyc;
        m_err     = i_wb_err & m_cyc;
      end
    end

    if (own_a) begin
      o_a_stall = m_stall;
      o_a_ack   = m_ack;
      o_a_err   = m_err;
    end
    if (own_b) begin
      o_b_stall = m_stall;
      o_b_ack   = m_ack;
      o_b_err   = m_err;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    nout_nxt  = nout;
    wd_nxt    = wd;

    case (state)
      IDLE: begin
        nout_nxt = '0;
        wd_nxt   = '0;
        if (i_a_cyc && i_b_cyc)
          state_nxt = last_owner ? OWN_A : OWN_B;
        else if (i_a_cyc)
          state_nxt = OWN_A;
        else if (i_b_cyc)
          state_nxt = OWN_B;
      end

      OWN_A, OWN_B: begin
        if (!m_cyc) begin
          // Responses still in flight for the abandoned cycle are dropped.
          state_nxt = IDLE;
          last_nxt  = own_b;
          nout_nxt  = '0;
          wd_nxt    = '0;
        end else if (wd_fire) begin
          state_nxt = ABORT;
          last_nxt  = own_b;
          nout_nxt  = '0;
          wd_nxt    = '0;
        end else if (i_wb_err) begin
          nout_nxt = '0;
          wd_nxt   = '0;
        end else begin
          if (accept && !i_wb_ack)
            nout_nxt = nout + LGOUT'(1);
          else if (!accept && i_wb_ack && (nout != '0))
            nout_nxt = nout - LGOUT'(1);

          if ((TIMEOUT != 0) && (nout != '0) && !i_wb_ack)
            wd_nxt = wd + WDW'(1);
          else
            wd_nxt = '0;
        end
      end

      ABORT: begin
        nout_nxt = '0;
        wd_nxt   = '0;
        // last_owner already names the aborted master.
        if (!(last_owner ? i_b_cyc : i_a_cyc))
          state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      nout       <= '0;
      wd         <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      nout       <= nout_nxt;
      wd         <= wd_nxt;
    end
  end

endmodule

// File: tb/tb_wbdualarb.sv
// Directed bench for wbdualarb (AW=DW=16, LGOUT=2, TIMEOUT=8).
// Stimulus pushes every expected master response (ack/err plus read data)
// into exp_q; the monitor pops one entry whenever any response strobe is
// high. Level checks on cyc/stb/stall/state are made inline.
module tb_wbdualarb;
  localparam int AW = 16;
  localparam int DW = 16;

  localparam logic [3:0] RA = 4'b1000;
  localparam logic [3:0] EA = 4'b0100;
  localparam logic [3:0] RB = 4'b0010;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [AW-1:0] a_addr, b_addr, wb_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, wb_wdata, wb_rdata;
  logic [1:0]    a_sel, b_sel, wb_sel;
  logic          a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic          wb_cyc, wb_stb, wb_we, wb_ack, wb_stall, wb_err;
  logic [1:0]    dbg_state;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            acc_cnt  = 0;
  int            acc_base;
  logic [19:0]   exp_q[$];
  logic [19:0]   obs, e_resp;

  always #5 clk = ~clk;

  wbdualarb #(.AW(AW), .DW(DW), .LGOUT(2), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr),
    .i_a_data(a_wdata), .i_a_sel(a_sel),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err), .o_a_data(a_rdata),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr),
    .i_b_data(b_wdata), .i_b_sel(b_sel),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err), .o_b_data(b_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .i_wb_data(wb_rdata),
    .o_dbg_state(dbg_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] kind, input logic [DW-1:0] d);
    exp_q.push_back({kind, d});
  endtask

  task automatic clr_inputs();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_sel = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_sel = '0;
    wb_ack = 0; wb_stall = 0; wb_err = 0; wb_rdata = '0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clr_inputs();
    step();
    rst = 1'b0;
  endtask

  // Monitor: response scoreboard and request-acceptance counter
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_stb && !a_stall) acc_cnt++;
      if (a_ack || a_err || b_ack || b_err) begin
        obs = {a_ack, a_err, b_ack, b_err, (a_ack || a_err) ? a_rdata : b_rdata};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got %h expected none at %0t", obs, $time);
        end else begin
          e_resp = exp_q.pop_front();
          chk("resp", {12'd0, obs}, {12'd0, e_resp});
        end
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    clr_inputs();
    a_cyc = 1; b_cyc = 1; wb_ack = 1; wb_err = 1; wb_rdata = 16'hbeef;
    mid();
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_a_stall", a_stall, 1);
    chk("rst_b_stall", b_stall, 1);
    chk("rst_acks", {a_ack, a_err, b_ack, b_err}, 0);
    chk("rst_a_data", a_rdata, 0);
    chk("rst_state", dbg_state, 0);
    do_reset();

    // ---------------- tie from reset: A first, then B after one idle ----
    step();
    a_cyc = 1; a_stb = 1; a_addr = 16'h00a1;
    b_cyc = 1; b_stb = 1; b_addr = 16'h00b1;
    mid();
    chk("tie_idle_cyc", wb_cyc, 0);
    step();
    mid();
    chk("tie_state_a", dbg_state, 1);
    chk("tie_addr_a", wb_addr, 16'h00a1);
    chk("tie_a_stall", a_stall, 0);
    chk("tie_b_stall", b_stall, 1);
    step();
    a_stb = 0; wb_ack = 1; wb_rdata = 16'h1111;
    push(RA, 16'h1111);
    mid();
    chk("tie_b_noack", b_ack, 0);
    step();
    wb_ack = 0; wb_rdata = '0; a_cyc = 0;
    mid();
    chk("tie_drop_cyc", wb_cyc, 0);
    step();
    mid();
    chk("tie_gap_idle", dbg_state, 0);
    step();
    mid();
    chk("tie_state_b", dbg_state, 2);
    chk("tie_addr_b", wb_addr, 16'h00b1);
    chk("tie_stb_b", wb_stb, 1);
    step();
    b_stb = 0; wb_ack = 1; wb_rdata = 16'h2222;
    push(RB, 16'h2222);
    mid();
    step();
    wb_ack = 0; wb_rdata = '0; b_cyc = 0;
    mid();
    step();

    // ---------------- single write from A, B idle ----------------
    step();
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 16'h1234; a_wdata = 16'h0f0f; a_sel = 2'b01;
    mid();
    chk("t1_idle_cyc", wb_cyc, 0);
    step();
    mid();
    chk("t1_cyc", wb_cyc, 1);
    chk("t1_stb", wb_stb, 1);
    chk("t1_addr", wb_addr, 16'h1234);
    chk("t1_wdata", wb_wdata, 16'h0f0f);
    chk("t1_sel", wb_sel, 2'b01);
    chk("t1_we", wb_we, 1);
    step();
    a_stb = 0; wb_ack = 1; wb_rdata = 16'h5a5a;
    push(RA, 16'h5a5a);
    mid();
    chk("t1_b_noack", b_ack, 0);
    step();
    wb_ack = 0; wb_rdata = '0; a_cyc = 0; a_we = 0;
    mid();
    chk("t1_drop_cyc", wb_cyc, 0);
    step();

    // ---------------- tie after A owned last: B wins ----------------
    step();
    a_cyc = 1; b_cyc = 1;
    mid();
    step();
    mid();
    chk("rr_state_b", dbg_state, 2);
    chk("rr_b_stall", b_stall, 0);
    chk("rr_a_stall", a_stall, 1);
    step();
    a_cyc = 0; b_cyc = 0;
    mid();
    step();

    // ---------------- outstanding limit (3 with LGOUT=2) ----------------
    do_reset();
    acc_base = acc_cnt;
    step();
    a_cyc = 1; a_stb = 1; a_addr = 16'h0300;
    mid();
    step(); mid(); chk("lim_stall0", a_stall, 0);
    step(); mid(); chk("lim_stall1", a_stall, 0);
    step(); mid(); chk("lim_stall2", a_stall, 0);
    step(); mid(); chk("lim_full", a_stall, 1);
    chk("lim_accepted3", acc_cnt - acc_base, 3);
    step(); mid(); chk("lim_full_hold", a_stall, 1);
    step();
    wb_ack = 1; wb_rdata = 16'h3001; push(RA, 16'h3001);
    mid();
    chk("lim_ack_stall", a_stall, 1);
    step();
    wb_ack = 0; wb_rdata = '0;
    mid();
    chk("lim_reopen", a_stall, 0);
    step();
    mid();
    chk("lim_refull", a_stall, 1);
    chk("lim_accepted4", acc_cnt - acc_base, 4);
    step();
    wb_ack = 1; wb_rdata = 16'h3002; push(RA, 16'h3002);
    mid();
    step();
    wb_rdata = 16'h3003; push(RA, 16'h3003);
    mid();
    chk("lim_ack_stb_open", a_stall, 0);
    step();
    wb_ack = 0; wb_rdata = '0;
    mid();
    chk("lim_unchanged", a_stall, 0);
    step();
    a_stb = 0;
    mid();
    chk("lim_full_again", a_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_ack = 1; wb_rdata = 16'h3010 + 16'(i); push(RA, 16'h3010 + 16'(i));
      mid();
    end
    step();
    wb_ack = 0; wb_rdata = '0; a_cyc = 0;
    mid();
    chk("lim_drop_cyc", wb_cyc, 0);
    step();

    // ---------------- watchdog abort, B waiting ----------------
    do_reset();
    step();
    a_cyc = 1; a_stb = 1; a_addr = 16'h0400;
    mid();
    step();
    mid();
    chk("wd_grant", a_stall, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        a_stb = 0;
        b_cyc = 1; b_stb = 1; b_addr = 16'h0b40;
      end
      if (k == 8) push(EA, 16'h0000);
      mid();
      if (k < 8) begin
        chk("wd_no_err", a_err, 0);
        chk("wd_cyc_held", wb_cyc, 1);
      end else begin
        chk("wd_fire_cyc", wb_cyc, 0);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      mid();
      chk("wd_abort_state", dbg_state, 3);
      chk("wd_abort_cyc", wb_cyc, 0);
      chk("wd_abort_b_stall", b_stall, 1);
    end
    step();
    a_cyc = 0;
    mid();
    chk("wd_abort_exit", dbg_state, 3);
    step();
    mid();
    chk("wd_idle", dbg_state, 0);
    step();
    mid();
    chk("wd_b_state", dbg_state, 2);
    chk("wd_b_addr", wb_addr, 16'h0b40);
    step();
    b_stb = 0; wb_ack = 1; wb_rdata = 16'h4444; push(RB, 16'h4444);
    mid();
    step();
    wb_ack = 0; wb_rdata = '0; b_cyc = 0;
    mid();
    step();

    // ---------------- bus error on 2nd pipelined request ----------------
    do_reset();
    step();
    a_cyc = 1; a_stb = 1; a_addr = 16'h0500;
    mid();
    step(); mid();
    step(); mid();
    step();
    wb_ack = 1; wb_rdata = 16'h5001; push(RA, 16'h5001);
    mid();
    step();
    wb_ack = 0; wb_rdata = '0; wb_err = 1; push(EA, 16'h0000);
    mid();
    chk("err_cyc_held", wb_cyc, 1);
    step();
    wb_err = 0; a_stb = 0;
    mid();
    chk("err_stall_open", a_stall, 0);
    // nout must be 0 now: an idle wait past TIMEOUT must not raise an error
    for (int k = 0; k < 10; k++) begin
      step();
      mid();
    end
    chk("err_still_own", dbg_state, 1);
    step();
    a_cyc = 0;
    mid();
    step();
    mid();
    chk("err_idle", dbg_state, 0);

    // ---------------- asynchronous reset while B owns ----------------
    step();
    b_cyc = 1; b_stb = 1; b_addr = 16'h0600;
    mid();
    step(); mid();
    chk("ar_own_b", dbg_state, 2);
    step(); mid();
    step();
    b_stb = 0;
    mid();
    chk("ar_cyc_before", wb_cyc, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_cyc", wb_cyc, 0);
    chk("ar_b_stall", b_stall, 1);
    chk("ar_state", dbg_state, 0);
    step();
    step();
    rst = 1'b0;
    a_cyc = 1; a_stb = 1; a_addr = 16'h0a60;
    mid();
    chk("ar_idle", dbg_state, 0);
    step();
    mid();
    chk("ar_tie_a", dbg_state, 1);
    chk("ar_tie_addr", wb_addr, 16'h0a60);
    step();
    a_cyc = 0; a_stb = 0; b_cyc = 0;
    mid();
    step();
    mid();

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
